// File: rtl/matrix_row_scanner.sv
// Scan controller for a 16x16 LED matrix: per row it fetches two glyph bytes,
// shifts them out to the column drivers, latches, dwells, and scrolls the image.
module matrix_row_scanner #(
    parameter int DWELL           = 1000,
    parameter int FRAMES_PER_STEP = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    output logic [6:0] rom_addr,
    input  logic [7:0] rom_dout,
    output logic       ser_data,
    output logic       ser_clk,
    output logic       ser_latch,
    output logic [3:0] row_sel,
    output logic       oe_n,
    output logic       frame_done,
    output logic [5:0] scroll_off
);

    localparam int              DW         = $clog2(DWELL + 1);
    localparam int              FW         = $clog2(FRAMES_PER_STEP + 1);
    localparam logic [DW-1:0]   DWELL_LOAD = DW'(DWELL - 1);
    localparam logic [FW-1:0]   FRAME_LAST = FW'(FRAMES_PER_STEP - 1);

    typedef enum logic [2:0] {IDLE, A0, A1, A2, SHIFT, LATCH, DWELL_ST} state_t;

    state_t        state, state_nx;
    logic [3:0]    row, row_nx;
    logic [5:0]    scroll_nx, g, g_nx;
    logic [FW-1:0] frame_cnt;
    logic [DW-1:0] dwell_cnt;
    logic [4:0]    shift_cnt;
    logic [15:0]   shreg;
    logic          dwell_end, frame_end, frame_step;

    always_comb begin
        dwell_end  = (state == DWELL_ST) && (dwell_cnt == '0);
        frame_end  = dwell_end && (row == 4'd15);
        frame_step = frame_end && (frame_cnt == FRAME_LAST);

        state_nx = state;
        case (state)
            IDLE:     if (enable) state_nx = A0;
            A0:       state_nx = A1;
            A1:       state_nx = A2;
            A2:       state_nx = SHIFT;
            SHIFT:    if (shift_cnt == 5'd0) state_nx = LATCH;
            LATCH:    state_nx = DWELL_ST;
            DWELL_ST: if (dwell_end) state_nx = enable ? A0 : IDLE;
            default:  state_nx = IDLE;
        endcase

        row_nx = row;
        if (dwell_end) row_nx = enable ? row + 4'd1 : 4'd0;
        scroll_nx = frame_step ? scroll_off + 6'd1 : scroll_off;
        g         = scroll_off + {2'b00, row};
        g_nx      = scroll_nx + {2'b00, row_nx};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            row        <= '0;
            scroll_off <= '0;
            frame_cnt  <= '0;
            frame_done <= 1'b0;
            rom_addr   <= '0;
            row_sel    <= '0;
            shreg      <= '0;
            shift_cnt  <= '0;
            dwell_cnt  <= '0;
            ser_data   <= 1'b0;
            ser_clk    <= 1'b0;
            ser_latch  <= 1'b0;
            oe_n       <= 1'b1;
        end else begin
            state      <= state_nx;
            row        <= row_nx;
            scroll_off <= scroll_nx;
            frame_done <= frame_end;
            if (frame_end) frame_cnt <= frame_step ? '0 : frame_cnt + FW'(1);

            if (state_nx == A0)      rom_addr <= {g_nx, 1'b0};
            else if (state_nx == A1) rom_addr <= {g, 1'b1};

            case (state)
                A1: shreg[15:8] <= rom_dout;
                A2: begin
                    shreg[7:0] <= rom_dout;
                    shift_cnt  <= 5'd31;
                end
                SHIFT: begin
                    shift_cnt <= shift_cnt - 5'd1;
                    if (!shift_cnt[0]) shreg <= {shreg[14:0], 1'b0};
                end
                LATCH:    dwell_cnt <= DWELL_LOAD;
                DWELL_ST: if (!dwell_end) dwell_cnt <= dwell_cnt - DW'(1);
                default: ;
            endcase

            // Serial pins are registered from next-cycle values so the driver never sees glitches.
            ser_clk   <= (state == SHIFT) && shift_cnt[0];
            ser_latch <= (state_nx == LATCH);
            if (state == A2)
                ser_data <= shreg[15];
            else if (state == SHIFT && shift_cnt != 5'd0)
                ser_data <= shift_cnt[0] ? shreg[15] : shreg[14];
            else
                ser_data <= 1'b0;

            if (state_nx == LATCH) row_sel <= row;
            if (state_nx == DWELL_ST)                        oe_n <= 1'b0;
            else if (state_nx == IDLE || state_nx == LATCH) oe_n <= 1'b1;
        end
    end

endmodule

// File: tb/tb_matrix_row_scanner.sv
// Directed bench for matrix_row_scanner: a row table for frame 0/1, plus scroll,
// enable-drop, mid-dwell reset and scroll-wrap sequences.
module tb_matrix_row_scanner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, enable;
    logic [6:0] rom_addr;
    logic [7:0] rom_dout;
    logic       ser_data, ser_clk, ser_latch, oe_n, frame_done;
    logic [3:0] row_sel;
    logic [5:0] scroll_off;

    logic       w_rst, w_enable;
    logic [6:0] w_rom_addr;
    logic [7:0] w_rom_dout;
    logic       w_ser_data, w_ser_clk, w_ser_latch, w_oe_n, w_frame_done;
    logic [3:0] w_row_sel;
    logic [5:0] w_scroll_off;

    matrix_row_scanner #(.DWELL(4), .FRAMES_PER_STEP(2)) dut (
        .clk(clk), .rst(rst), .enable(enable), .rom_addr(rom_addr), .rom_dout(rom_dout),
        .ser_data(ser_data), .ser_clk(ser_clk), .ser_latch(ser_latch), .row_sel(row_sel),
        .oe_n(oe_n), .frame_done(frame_done), .scroll_off(scroll_off)
    );

    matrix_row_scanner #(.DWELL(1), .FRAMES_PER_STEP(1)) dut_wrap (
        .clk(clk), .rst(w_rst), .enable(w_enable), .rom_addr(w_rom_addr), .rom_dout(w_rom_dout),
        .ser_data(w_ser_data), .ser_clk(w_ser_clk), .ser_latch(w_ser_latch), .row_sel(w_row_sel),
        .oe_n(w_oe_n), .frame_done(w_frame_done), .scroll_off(w_scroll_off)
    );

    // ROM model: each byte holds its own address.
    always @(posedge clk) begin
        rom_dout   <= {1'b0, rom_addr};
        w_rom_dout <= {1'b0, w_rom_addr};
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int          a0;
        int          a1;
        logic [15:0] word;
        int          edges;
        int          hold_err;
        int          latch_cnt;
        int          latch_pos;
        int          latch_rs;
        int          latch_oe;
        int          dwell_lit;
        int          dwell_rs;
        int          fd0;
        int          fd_rest;
    } row_t;

    typedef struct {
        int          a0;
        int          a1;
        logic [15:0] word;
    } vec_t;

    // Called at the negedge inside a row's A0 cycle; returns at the next row's A0.
    task automatic run_row(input int drop_at, output row_t r);
        logic pc, pd;
        r  = '{default: 0};
        pc = 1'b0;
        pd = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (c == 0) r.a0 = int'(rom_addr);
            if (c == 1) r.a1 = int'(rom_addr);
            if (ser_clk === 1'b1 && pc == 1'b0) begin
                r.word = {r.word[14:0], ser_data};
                r.edges++;
                if (ser_data !== pd) r.hold_err++;
            end
            pc = ser_clk;
            pd = ser_data;
            if (ser_latch === 1'b1) begin
                r.latch_cnt++;
                r.latch_pos = c;
                r.latch_rs  = int'(row_sel);
                r.latch_oe  = int'(oe_n);
            end
            if (c >= 36 && oe_n === 1'b0 && ser_latch === 1'b0) r.dwell_lit++;
            if (c == 39) r.dwell_rs = int'(row_sel);
            if (frame_done === 1'b1) begin
                if (c == 0) r.fd0 = 1;
                else r.fd_rest++;
            end
            if (c == drop_at) enable = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic check_row(input string tag, input row_t r, input int a0, input int a1,
                             input logic [15:0] word, input int rs, input int fd0);
        check({tag, " addr0"}, r.a0, a0);
        check({tag, " addr1"}, r.a1, a1);
        check({tag, " shifted word"}, r.word, word);
        check({tag, " ser_clk edges"}, r.edges, 16);
        check({tag, " ser_data hold"}, r.hold_err, 0);
        check({tag, " latch count"}, r.latch_cnt, 1);
        check({tag, " latch position"}, r.latch_pos, 35);
        check({tag, " oe_n at latch"}, r.latch_oe, 1);
        check({tag, " dwell lit cycles"}, r.dwell_lit, 4);
        check({tag, " row_sel in dwell"}, r.dwell_rs, rs);
        check({tag, " frame_done first cycle"}, r.fd0, fd0);
        check({tag, " frame_done elsewhere"}, r.fd_rest, 0);
    endtask

    task automatic check_reset(input string tag);
        check({tag, " rom_addr"}, rom_addr, 0);
        check({tag, " ser_data"}, ser_data, 0);
        check({tag, " ser_clk"}, ser_clk, 0);
        check({tag, " ser_latch"}, ser_latch, 0);
        check({tag, " row_sel"}, row_sel, 0);
        check({tag, " oe_n"}, oe_n, 1);
        check({tag, " frame_done"}, frame_done, 0);
        check({tag, " scroll_off"}, scroll_off, 0);
    endtask

    vec_t vecs[16];
    row_t res;

    initial begin
        int bad, n;
        logic [6:0] a_r0a, a_r0b, a_r1a, a_r1b;

        vecs = '{
            '{0,  1,  16'h0001}, '{2,  3,  16'h0203}, '{4,  5,  16'h0405}, '{6,  7,  16'h0607},
            '{8,  9,  16'h0809}, '{10, 11, 16'h0A0B}, '{12, 13, 16'h0C0D}, '{14, 15, 16'h0E0F},
            '{16, 17, 16'h1011}, '{18, 19, 16'h1213}, '{20, 21, 16'h1415}, '{22, 23, 16'h1617},
            '{24, 25, 16'h1819}, '{26, 27, 16'h1A1B}, '{28, 29, 16'h1C1D}, '{30, 31, 16'h1E1F}
        };

        rst = 1'b1; enable = 1'b0; w_rst = 1'b1; w_enable = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst = 1'b0; w_rst = 1'b0;

        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (oe_n !== 1'b1 || rom_addr !== 7'd0 || ser_data !== 1'b0 || ser_clk !== 1'b0 ||
                ser_latch !== 1'b0 || row_sel !== 4'd0 || frame_done !== 1'b0 || scroll_off !== 6'd0)
                bad++;
        end
        check("idle outputs quiet", bad, 0);

        enable = 1'b1;
        @(negedge clk);

        // Frame 0 and frame 1 at scroll 0: row r reads 2r, 2r+1.
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 16; i++) begin
                run_row(-1, res);
                check_row($sformatf("f%0d row%0d", f, i), res, vecs[i].a0, vecs[i].a1, vecs[i].word,
                          i, (f == 1 && i == 0) ? 1 : 0);
                if (f == 0 && i == 0) check("row0 row_sel at latch", res.latch_rs, 0);
            end
            if (f == 0) check("scroll after 1 frame", scroll_off, 0);
        end
        check("scroll after 2 frames", scroll_off, 1);
        check("frame_done after frame 2", frame_done, 1);

        // Row 0 at scroll 1, enable dropped during bit 5 of the shift.
        run_row(13, res);
        check_row("drop row", res, 2, 3, 16'h0203, 0, 1);
        bad = 0;
        repeat (10) begin
            if (oe_n !== 1'b1 || ser_clk !== 1'b0 || ser_latch !== 1'b0 || frame_done !== 1'b0) bad++;
            @(negedge clk);
        end
        check("idle after drop", bad, 0);
        check("scroll kept in idle", scroll_off, 1);

        enable = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            run_row(-1, res);
            check_row($sformatf("s1 row%0d", i), res, vecs[i+1].a0, vecs[i+1].a1, vecs[i+1].word, i, 0);
        end

        // Row 7: reset during its second dwell cycle.
        repeat (37) @(negedge clk);
        check("row7 dwell oe_n", oe_n, 0);
        check("row7 dwell row_sel", row_sel, 7);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset("mid-dwell reset");
        @(negedge clk);
        run_row(-1, res);
        check_row("post-reset row0", res, 0, 1, 16'h0001, 0, 0);

        // Scroll wrap on the DWELL=1, one-frame-per-step instance.
        w_enable = 1'b1;
        n = 0;
        while (n < 45000 && w_scroll_off !== 6'd63) begin
            @(negedge clk);
            n++;
        end
        check("wrap scroll reaches 63", w_scroll_off, 63);
        a_r0a = w_rom_addr;
        a_r0b = '0; a_r1a = '1; a_r1b = '1;
        n = 0;
        while (n < 800 && w_scroll_off === 6'd63) begin
            @(negedge clk);
            n++;
            if (n == 1)  a_r0b = w_rom_addr;
            if (n == 37) a_r1a = w_rom_addr;
            if (n == 38) a_r1b = w_rom_addr;
        end
        check("wrap row0 addr0", a_r0a, 126);
        check("wrap row0 addr1", a_r0b, 127);
        check("wrap row1 addr0", a_r1a, 0);
        check("wrap row1 addr1", a_r1b, 1);
        check("wrap frame length", n, 592);
        check("wrap scroll 63 to 0", w_scroll_off, 0);
        check("wrap frame_done", w_frame_done, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
